pipe_pal_elastic: RTL

//   Parametrised elastic valid/ready pipeline: N_STAGES register stages plus an input skid slot.

---
 rtl/pipe_pal_elastic.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipe_pal_elastic.sv
// pipe_pal_elastic: elastic valid/ready pipeline with N_STAGES register stages,
// an input skid slot, a wrapping sequence tag per accepted word, flush and a
// registered occupancy count. o_ready is driven only by the skid-valid flop.
module pipe_pal_elastic #(
    parameter int W_DATA   = 32,
    parameter int N_STAGES = 3,
    parameter int W_TAG    = 4,
    localparam int W_OCC   = $clog2(N_STAGES + 2)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W_DATA-1:0] o_data,
    output logic [W_TAG-1:0]  o_tag,
    output logic [W_OCC-1:0]  o_occ
);

    logic [N_STAGES-1:0] vld_q,  vld_d;
    logic [W_DATA-1:0]   data_q [N_STAGES];
    logic [W_DATA-1:0]   data_d [N_STAGES];
    logic [W_TAG-1:0]    tag_q  [N_STAGES];
    logic [W_TAG-1:0]    tag_d  [N_STAGES];

    logic                skid_vld_q,  skid_vld_d;
    logic [W_DATA-1:0]   skid_data_q, skid_data_d;
    logic [W_TAG-1:0]    skid_tag_q,  skid_tag_d;

    logic [W_TAG-1:0]    tag_cnt_q, tag_cnt_d;
    logic [W_OCC-1:0]    occ_q,     occ_d;

    logic [N_STAGES-1:0] load;
    logic                in_xfer;
    logic                out_xfer;

    assign o_ready = !skid_vld_q;
    assign o_valid = vld_q[N_STAGES-1];
    assign o_data  = data_q[N_STAGES-1];
    assign o_tag   = tag_q[N_STAGES-1];
    assign o_occ   = occ_q;

    // Ready chain: a stage loads when it is empty or the stage after it drains.
    always_comb begin
        logic carry;
        carry = i_ready;
        load  = '0;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            carry   = !vld_q[k] || carry;
            load[k] = carry;
        end
        in_xfer  = i_valid && !skid_vld_q;
        out_xfer = vld_q[N_STAGES-1] && i_ready;
    end

    // Next state: shift loading stages, feed stage 0 from skid first, park
    // the incoming word in the skid when stage 0 cannot take it.
    always_comb begin
        vld_d       = vld_q;
        data_d      = data_q;
        tag_d       = tag_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;

        for (int k = N_STAGES - 1; k >= 1; k--) begin
            if (load[k]) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = data_q[k-1];
                tag_d[k]  = tag_q[k-1];
            end
        end

        if (load[0]) begin
            if (skid_vld_q) begin
                vld_d[0]  = 1'b1;
                data_d[0] = skid_data_q;
                tag_d[0]  = skid_tag_q;
            end else begin
                vld_d[0]  = in_xfer;
                data_d[0] = i_data;
                tag_d[0]  = tag_cnt_q;
            end
        end

        if (skid_vld_q && load[0]) begin
            skid_vld_d = 1'b0;
        end else if (in_xfer && !load[0]) begin
            skid_vld_d  = 1'b1;
            skid_data_d = i_data;
            skid_tag_d  = tag_cnt_q;
        end

        tag_cnt_d = tag_cnt_q + W_TAG'(in_xfer);
        occ_d     = occ_q + W_OCC'(in_xfer) - W_OCC'(out_xfer);

        // Flush drops every held word but the tag counter keeps counting.
        if (i_flush) begin
            vld_d      = '0;
            skid_vld_d = 1'b0;
            occ_d      = '0;
        end
    end

    // Control state: valids, tag counter and occupancy, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q      <= '0;
            skid_vld_q <= 1'b0;
            tag_cnt_q  <= '0;
            occ_q      <= '0;
        end else begin
            vld_q      <= vld_d;
            skid_vld_q <= skid_vld_d;
            tag_cnt_q  <= tag_cnt_d;
            occ_q      <= occ_d;
        end
    end

    // Payload registers need no reset; they are qualified by the valids.
    always_ff @(posedge i_clk) begin
        data_q      <= data_d;
        tag_q       <= tag_d;
        skid_data_q <= skid_data_d;
        skid_tag_q  <= skid_tag_d;
    end

endmodule
